// File: rtl/seq_alu_acc_pkg.sv
// Shared types and constants for the sequential accumulator ALU and its
// 7-segment display helper.
package seq_alu_acc_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_NEG  = 3'b101,
    OP_LOAD = 3'b110,
    OP_NOP  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } alu_state_t;

  // Segment order is {g,f,e,d,c,b,a}; a lit segment is 1.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] SEG_DASH = 7'b1000000;

endpackage

// File: rtl/seq_alu_acc_if.sv
// Operation request/response bundle between the board controls and the ALU.
interface seq_alu_acc_if #(
  parameter int NBITS = 4
);

  logic                    start;
  logic [2:0]              op;
  logic signed [NBITS-1:0] a;
  logic signed [NBITS-1:0] b;
  logic                    acc_sel;
  logic                    clr_ovf;
  logic                    busy;
  logic                    done;
  logic signed [NBITS-1:0] result;
  logic                    ovf;
  logic                    ovf_sticky;
  logic [7:0]              seg;

  modport master (
    output start, op, a, b, acc_sel, clr_ovf,
    input  busy, done, result, ovf, ovf_sticky, seg
  );

  modport slave (
    input  start, op, a, b, acc_sel, clr_ovf,
    output busy, done, result, ovf, ovf_sticky, seg
  );

endinterface

// File: rtl/seg7_signed.sv
// Sign-magnitude 7-segment encoder: bit 7 is the minus sign, bits 6:0 show
// the hex glyph of the magnitude, or a dash when it does not fit one digit.
module seg7_signed
  import seq_alu_acc_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic signed [NBITS-1:0] value,
  output logic [7:0]              seg
);

  logic [NBITS-1:0] mag;
  logic [7:0]       mag8;

  // Magnitude of the most negative value still fits NBITS unsigned bits.
  always_comb begin
    mag    = value[NBITS-1] ? $unsigned(-value) : $unsigned(value);
    mag8   = 8'(mag);
    seg[7] = value[NBITS-1];
    seg[6:0] = (mag8 > 8'd15) ? SEG_DASH : SEG_HEX[mag8[3:0]];
  end

endmodule

// File: rtl/seq_alu_acc.sv
// Signed ALU with result accumulator: one operation per start pulse, single
// cycle for logic/arith ops, NBITS-cycle shift-add multiply, sticky overflow.
module seq_alu_acc
  import seq_alu_acc_pkg::*;
#(
  parameter int NBITS  = 4,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk_2,
  input  logic         reset_n,
  seq_alu_acc_if.slave bus
);

  localparam int              PW      = 2 * NBITS;
  localparam logic [PW-1:0]   POS_LIM = PW'((1 << (NBITS - 1)) - 1);
  localparam logic [PW-1:0]   NEG_LIM = PW'(1 << (NBITS - 1));
  localparam logic [3:0]      LAST_IT = 4'(NBITS - 1);

  alu_state_t              state_q, state_d;
  alu_op_t                 op_q, op_d;
  logic signed [NBITS-1:0] opa_q, opa_d, opb_q, opb_d;
  logic signed [NBITS-1:0] result_q, result_d;
  logic                    ovf_q, ovf_d, sticky_q, sticky_d, done_q, done_d;
  logic [PW-1:0]           mcand_q, mcand_d, prod_q, prod_d;
  logic [NBITS-1:0]        mplier_q, mplier_d;
  logic                    neg_q, neg_d;
  logic [3:0]              cnt_q, cnt_d;
  logic signed [NBITS-1:0] a_sel;
  logic signed [NBITS:0]   sum;
  logic [PW-1:0]           prod_next;

  function automatic logic [NBITS-1:0] magnitude(input logic signed [NBITS-1:0] v);
    return v[NBITS-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // One guard bit makes every sum/difference of two NBITS operands exact.
  function automatic logic signed [NBITS:0] addsub(input logic signed [NBITS-1:0] x,
                                                   input logic signed [NBITS-1:0] y,
                                                   input logic sub);
    logic signed [NBITS:0] xe, ye;
    xe = {x[NBITS-1], x};
    ye = {y[NBITS-1], y};
    return sub ? (xe - ye) : (xe + ye);
  endfunction

  function automatic logic range_ovf(input logic signed [NBITS:0] r);
    return r[NBITS] ^ r[NBITS-1];
  endfunction

  // A negative product may reach one step further than a positive one.
  function automatic logic mul_ovf(input logic [PW-1:0] p, input logic neg);
    return neg ? (p > NEG_LIM) : (p > POS_LIM);
  endfunction

  function automatic logic signed [NBITS-1:0] mul_wrap(input logic [PW-1:0] p,
                                                       input logic neg);
    logic [PW-1:0] s;
    s = neg ? -p : p;
    return s[NBITS-1:0];
  endfunction

  // Next-state, datapath and handshake decisions for the IDLE/EXEC/MUL sequencer.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    a_sel     = bus.acc_sel ? result_q : bus.a;
    sum       = '0;
    prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d  = alu_op_t'(bus.op);
          opa_d = a_sel;
          opb_d = bus.b;
          if ((alu_op_t'(bus.op) == OP_MUL) && MUL_EN) begin
            state_d  = ST_MUL;
            prod_d   = '0;
            mcand_d  = PW'(magnitude(a_sel));
            mplier_d = magnitude(bus.b);
            neg_d    = a_sel[NBITS-1] ^ bus.b[NBITS-1];
            cnt_d    = '0;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        case (op_q)
          OP_AND:  result_d = opa_q & opb_q;
          OP_OR:   result_d = opa_q | opb_q;
          OP_ADD: begin
            sum      = addsub(opa_q, opb_q, 1'b0);
            result_d = sum[NBITS-1:0];
            ovf_d    = range_ovf(sum);
          end
          OP_SUB: begin
            sum      = addsub(opa_q, opb_q, 1'b1);
            result_d = sum[NBITS-1:0];
            ovf_d    = range_ovf(sum);
          end
          OP_NEG: begin
            result_d = -opa_q;
            ovf_d    = opa_q[NBITS-1] & ~(|opa_q[NBITS-2:0]);
          end
          OP_LOAD: result_d = opb_q;
          // NOP, and MUL when the multiplier is not built, leave result alone.
          default: result_d = result_q;
        endcase
      end
      ST_MUL: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == LAST_IT) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          result_d = mul_wrap(prod_next, neg_q);
          ovf_d    = mul_ovf(prod_next, neg_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A same-cycle overflow wins over the clear request.
    sticky_d = (done_d & ovf_d) | (sticky_q & ~bus.clr_ovf);
  end

  // Control and visible result registers; reset aborts any operation in flight.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // Operand and multiplier working registers; always loaded before use.
  always_ff @(posedge clk_2) begin
    op_q     <= op_d;
    opa_q    <= opa_d;
    opb_q    <= opb_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
    neg_q    <= neg_d;
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;

  seg7_signed #(.NBITS(NBITS)) u_seg7 (
    .value (result_q),
    .seg   (bus.seg)
  );

endmodule

// File: tb/tb_seq_alu_acc.sv
// Bench for seq_alu_acc (NBITS=4): directed scenarios plus randomized ops
// compared against an integer-arithmetic reference model.
module tb_seq_alu_acc;

  localparam int NB   = 4;
  localparam int MINV = -(1 << (NB - 1));
  localparam int MAXV = (1 << (NB - 1)) - 1;
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk_2 = 1'b0;
  logic reset_n;
  always #5 clk_2 = ~clk_2;

  seq_alu_acc_if #(.NBITS(NB)) bus ();

  seq_alu_acc #(.NBITS(NB), .MUL_EN(1'b1)) dut (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_acc;
  bit m_sticky;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int wrap(input int t);
    int r;
    r = t & ((1 << NB) - 1);
    if (r > MAXV) r -= (1 << NB);
    return r;
  endfunction

  function automatic int seg_of(input int v);
    int mag;
    logic [6:0] g;
    mag = (v < 0) ? -v : v;
    g = (mag > 15) ? 7'b1000000 : GLYPH[mag];
    return ((v < 0) ? 128 : 0) + int'(g);
  endfunction

  // Reference: true integer result, overflow = outside NB-bit signed range.
  task automatic ref_op(input int op, input int av, input int bv,
                        output int val, output bit ov);
    int t;
    ov  = 1'b0;
    val = m_acc;
    t   = 0;
    case (op)
      0: val = wrap(av & bv);
      1: val = wrap(av | bv);
      2, 3, 4, 5: begin
        case (op)
          2: t = av + bv;
          3: t = av - bv;
          4: t = av * bv;
          default: t = -av;
        endcase
        ov  = (t < MINV) || (t > MAXV);
        val = wrap(t);
      end
      6: val = bv;
      default: val = m_acc;
    endcase
  endtask

  task automatic drive_start(input int op, input int av, input int bv, input bit acc);
    bus.start   = 1'b1;
    bus.op      = 3'(op);
    bus.a       = NB'(av);
    bus.b       = NB'(bv);
    bus.acc_sel = acc;
  endtask

  task automatic do_op(input int op, input int av, input int bv, input bit acc, input bit clr);
    int exp_v, a_eff, lat, cyc;
    bit exp_o;
    a_eff = acc ? m_acc : av;
    ref_op(op, a_eff, bv, exp_v, exp_o);
    lat = (op == 4) ? NB : 1;
    drive_start(op, av, bv, acc);
    @(posedge clk_2); #1;
    bus.start   = 1'b0;
    bus.clr_ovf = clr;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20) begin
      check_eq("busy_during_op", int'(bus.busy), 1);
      @(posedge clk_2); #1;
      cyc++;
    end
    bus.clr_ovf = 1'b0;
    check_eq($sformatf("latency_op%0d", op), cyc, lat);
    m_acc = exp_v;
    if (clr) m_sticky = 1'b0;
    if (exp_o) m_sticky = 1'b1;
    check_eq($sformatf("result_op%0d_a%0d_b%0d", op, a_eff, bv), int'(bus.result), m_acc);
    check_eq($sformatf("ovf_op%0d_a%0d_b%0d", op, a_eff, bv), int'(bus.ovf), int'(exp_o));
    check_eq("ovf_sticky", int'(bus.ovf_sticky), int'(m_sticky));
    check_eq("seg", int'(bus.seg), seg_of(m_acc));
    check_eq("busy_at_done", int'(bus.busy), 0);
    @(posedge clk_2); #1;
    check_eq("done_one_cycle", int'(bus.done), 0);
  endtask

  initial begin
    int nd, saw_res, rv, av, bv;
    bit ro;

    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 3'd0;
    bus.a       = '0;
    bus.b       = '0;
    bus.acc_sel = 1'b0;
    bus.clr_ovf = 1'b0;
    m_acc       = 0;
    m_sticky    = 1'b0;
    repeat (3) @(posedge clk_2);
    #1;
    check_eq("rst_result", int'(bus.result), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_done", int'(bus.done), 0);
    check_eq("rst_ovf", int'(bus.ovf), 0);
    check_eq("rst_sticky", int'(bus.ovf_sticky), 0);
    check_eq("rst_seg", int'(bus.seg), 8'h3F);
    reset_n = 1'b1;
    @(posedge clk_2); #1;

    // Load then accumulate.
    do_op(6, 0, 3, 1'b0, 1'b0);
    do_op(2, 0, 4, 1'b1, 1'b0);
    check_eq("acc_add_value", int'(bus.result), 7);

    // Positive overflow wraps to the most negative value.
    do_op(2, 7, 1, 1'b0, 1'b0);
    check_eq("add_wrap_value", int'(bus.result), -8);
    check_eq("add_wrap_seg", int'(bus.seg), 8'hFF);
    do_op(0, 5, 3, 1'b0, 1'b0);
    check_eq("and_keeps_sticky", int'(bus.ovf_sticky), 1);
    bus.clr_ovf = 1'b1;
    @(posedge clk_2); #1;
    bus.clr_ovf = 1'b0;
    m_sticky = 1'b0;
    check_eq("clr_sticky", int'(bus.ovf_sticky), 0);

    // Multiply, including a wrapping product, then NEG/SUB corners.
    do_op(4, -2, 3, 1'b0, 1'b0);
    check_eq("mul_neg6", int'(bus.result), -6);
    do_op(4, -3, 3, 1'b0, 1'b0);
    check_eq("mul_wrap7", int'(bus.result), 7);
    do_op(5, -8, 0, 1'b0, 1'b0);
    do_op(3, -8, 1, 1'b0, 1'b0);

    // A start during a multiply must be dropped.
    ref_op(4, -2, 3, rv, ro);
    drive_start(4, -2, 3, 1'b0);
    @(posedge clk_2); #1;
    bus.start = 1'b0;
    @(posedge clk_2); #1;
    @(posedge clk_2); #1;
    drive_start(6, 0, 1, 1'b0);
    @(posedge clk_2); #1;
    bus.start = 1'b0;
    nd = 0;
    saw_res = 999;
    for (int k = 0; k < 10; k++) begin
      if (bus.done === 1'b1) begin
        nd++;
        saw_res = int'(bus.result);
      end
      @(posedge clk_2); #1;
    end
    m_acc = rv;
    if (ro) m_sticky = 1'b1;
    check_eq("busy_start_done_count", nd, 1);
    check_eq("busy_start_result", saw_res, rv);
    check_eq("busy_start_final", int'(bus.result), rv);

    // Clear and overflowing done in the same cycle: the set wins.
    bus.clr_ovf = 1'b1;
    @(posedge clk_2); #1;
    bus.clr_ovf = 1'b0;
    m_sticky = 1'b0;
    do_op(2, 7, 7, 1'b0, 1'b1);
    check_eq("clr_vs_set_sticky", int'(bus.ovf_sticky), 1);

    // Reset in the middle of a multiply.
    do_op(6, 0, 5, 1'b0, 1'b0);
    drive_start(4, 3, 3, 1'b0);
    @(posedge clk_2); #1;
    bus.start = 1'b0;
    @(posedge clk_2); #1;
    @(posedge clk_2); #1;
    reset_n = 1'b0;
    #1;
    check_eq("midmul_rst_result", int'(bus.result), 0);
    check_eq("midmul_rst_busy", int'(bus.busy), 0);
    check_eq("midmul_rst_sticky", int'(bus.ovf_sticky), 0);
    check_eq("midmul_rst_seg", int'(bus.seg), 8'h3F);
    @(posedge clk_2); #1;
    reset_n = 1'b1;
    m_acc = 0;
    m_sticky = 1'b0;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done === 1'b1) nd++;
      @(posedge clk_2); #1;
    end
    check_eq("midmul_no_done", nd, 0);
    check_eq("midmul_result_after", int'(bus.result), 0);

    // Randomized operations, biased towards the range extremes.
    for (int i = 0; i < 80; i++) begin
      av = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? MINV : MAXV)
                                       : wrap(int'($urandom_range(0, 15)));
      bv = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? MINV : MAXV)
                                       : wrap(int'($urandom_range(0, 15)));
      do_op(int'($urandom_range(0, 7)), av, bv, bit'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
